// File: rtl/vx_issue_perf_ctr_if.sv
// Issue-stage handshake bundle observed by the performance counter unit.
// The master side is the issue pipeline; the slave side only monitors.
interface vx_issue_perf_ctr_if #(
    parameter int unsigned NUM_THREADS = 4
);
    logic                   ibuf_valid;
    logic                   ibuf_ready;
    logic                   scb_valid;
    logic                   scb_ready;
    logic [4:0]             ex_valid;
    logic [4:0]             ex_ready;
    logic [NUM_THREADS-1:0] issue_tmask;

    modport master (
        output ibuf_valid,
        output ibuf_ready,
        output scb_valid,
        output scb_ready,
        output ex_valid,
        output ex_ready,
        output issue_tmask
    );

    modport slave (
        input ibuf_valid,
        input ibuf_ready,
        input scb_valid,
        input scb_ready,
        input ex_valid,
        input ex_ready,
        input issue_tmask
    );
endinterface

// File: rtl/vx_issue_perf_ctr.sv
// Issue-stage performance counters: one registered event stage, then accumulation.
// Define PERF_CTR_SATURATE_EN to make every counter saturate instead of wrapping.
module vx_issue_perf_ctr #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned CTR_BITS    = 44
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                perf_en,
    input  logic                perf_clr,
    vx_issue_perf_ctr_if.slave  issue_if,
    output logic [CTR_BITS-1:0] ibf_stalls,
    output logic [CTR_BITS-1:0] scb_stalls,
    output logic [CTR_BITS-1:0] lsu_stalls,
    output logic [CTR_BITS-1:0] csr_stalls,
    output logic [CTR_BITS-1:0] alu_stalls,
    output logic [CTR_BITS-1:0] fpu_stalls,
    output logic [CTR_BITS-1:0] gpu_stalls,
    output logic [CTR_BITS-1:0] active_threads
);

    localparam int unsigned LANE_BITS = $clog2(NUM_THREADS + 1);
    localparam int unsigned NUM_EX    = 5;
    localparam int unsigned NUM_EV    = 2 + NUM_EX;
    localparam int unsigned EV_IBF    = 0;
    localparam int unsigned EV_SCB    = 1;
    localparam int unsigned EV_EX     = 2;

    logic [NUM_EV-1:0]    ev_d, ev_q;
    logic [LANE_BITS-1:0] lanes_d, lanes_q;
    logic                 fire;

    logic [CTR_BITS-1:0] stall_q [NUM_EV];
    logic [CTR_BITS-1:0] stall_d [NUM_EV];
    logic [CTR_BITS-1:0] thr_q;
    logic [CTR_BITS-1:0] thr_d;

    // Event decode
    always_comb begin
        ev_d = '0;
        ev_d[EV_IBF] = issue_if.ibuf_valid & ~issue_if.ibuf_ready;
        ev_d[EV_SCB] = issue_if.scb_valid & ~issue_if.scb_ready;
        ev_d[EV_EX +: NUM_EX] = issue_if.ex_valid & ~issue_if.ex_ready;
        // Dispatch is one-hot; a multi-hot fire still counts the lanes once.
        fire    = |(issue_if.ex_valid & issue_if.ex_ready);
        lanes_d = '0;
        if (fire) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                lanes_d = lanes_d + LANE_BITS'(issue_if.issue_tmask[i]);
            end
        end
    end

    // Event stage: perf_en only gates capture, so a registered event still retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_q    <= '0;
            lanes_q <= '0;
        end else if (perf_clr) begin
            ev_q    <= '0;
            lanes_q <= '0;
        end else if (perf_en) begin
            ev_q    <= ev_d;
            lanes_q <= lanes_d;
        end else begin
            ev_q    <= '0;
            lanes_q <= '0;
        end
    end

`ifdef PERF_CTR_SATURATE_EN
    localparam int unsigned SUM_BITS = CTR_BITS + 1;

    logic [SUM_BITS-1:0] stall_sum [NUM_EV];
    logic [SUM_BITS-1:0] thr_sum;

    // Sum one bit wider and clamp on carry-out.
    always_comb begin
        for (int k = 0; k < NUM_EV; k++) begin
            stall_sum[k] = {1'b0, stall_q[k]} + SUM_BITS'(ev_q[k]);
            stall_d[k]   = stall_sum[k][CTR_BITS] ? '1 : stall_sum[k][CTR_BITS-1:0];
        end
        thr_sum = {1'b0, thr_q} + SUM_BITS'(lanes_q);
        thr_d   = thr_sum[CTR_BITS] ? '1 : thr_sum[CTR_BITS-1:0];
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_EV; k++) begin
            stall_d[k] = stall_q[k] + CTR_BITS'(ev_q[k]);
        end
        thr_d = thr_q + CTR_BITS'(lanes_q);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_EV; k++) begin
                stall_q[k] <= '0;
            end
            thr_q <= '0;
        end else if (perf_clr) begin
            for (int k = 0; k < NUM_EV; k++) begin
                stall_q[k] <= '0;
            end
            thr_q <= '0;
        end else begin
            for (int k = 0; k < NUM_EV; k++) begin
                stall_q[k] <= stall_d[k];
            end
            thr_q <= thr_d;
        end
    end

    assign ibf_stalls     = stall_q[EV_IBF];
    assign scb_stalls     = stall_q[EV_SCB];
    assign lsu_stalls     = stall_q[EV_EX + 0];
    assign csr_stalls     = stall_q[EV_EX + 1];
    assign alu_stalls     = stall_q[EV_EX + 2];
    assign fpu_stalls     = stall_q[EV_EX + 3];
    assign gpu_stalls     = stall_q[EV_EX + 4];
    assign active_threads = thr_q;

endmodule

// File: tb/tb_vx_issue_perf_ctr.sv
// Directed bench for vx_issue_perf_ctr, built with CTR_BITS=8 so wrap/saturation is reachable.
// Expected wrap values follow PERF_CTR_SATURATE_EN when it is defined.
module tb_vx_issue_perf_ctr;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned CTR_BITS    = 8;

    logic clk;
    logic reset;
    logic perf_en;
    logic perf_clr;
    logic [CTR_BITS-1:0] ibf_stalls, scb_stalls, lsu_stalls, csr_stalls;
    logic [CTR_BITS-1:0] alu_stalls, fpu_stalls, gpu_stalls, active_threads;

    int n_tests;
    int n_fail;

    vx_issue_perf_ctr_if #(.NUM_THREADS(NUM_THREADS)) bus ();

    vx_issue_perf_ctr #(
        .NUM_THREADS(NUM_THREADS),
        .CTR_BITS   (CTR_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .perf_en       (perf_en),
        .perf_clr      (perf_clr),
        .issue_if      (bus),
        .ibf_stalls    (ibf_stalls),
        .scb_stalls    (scb_stalls),
        .lsu_stalls    (lsu_stalls),
        .csr_stalls    (csr_stalls),
        .alu_stalls    (alu_stalls),
        .fpu_stalls    (fpu_stalls),
        .gpu_stalls    (gpu_stalls),
        .active_threads(active_threads)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 ibf, 1 scb, 2 lsu, 3 csr, 4 alu, 5 fpu, 6 gpu, 7 active_threads
    function automatic logic [CTR_BITS-1:0] get_out(input int k);
        case (k)
            0:       return ibf_stalls;
            1:       return scb_stalls;
            2:       return lsu_stalls;
            3:       return csr_stalls;
            4:       return alu_stalls;
            5:       return fpu_stalls;
            6:       return gpu_stalls;
            default: return active_threads;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ibuf_valid  = 1'b0;
        bus.ibuf_ready  = 1'b0;
        bus.scb_valid   = 1'b0;
        bus.scb_ready   = 1'b0;
        bus.ex_valid    = 5'b0;
        bus.ex_ready    = 5'b0;
        bus.issue_tmask = '0;
    endtask

    task automatic do_clear();
        set_idle();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [CTR_BITS-1:0] got;
        // Stalls present while reset is held: counters must stay at zero.
        bus.ibuf_valid = 1'b1;
        bus.scb_valid  = 1'b1;
        bus.ex_valid   = 5'b11111;
        tick();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            got = get_out(k);
            n_tests++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %0d, expected 0", k, got);
            end
        end
        set_idle();
        #2 reset = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        for (int k = 0; k < 8; k++) begin
            got = get_out(k);
            n_tests++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL idle_20[%0d]: got %0d, expected 0", k, got);
            end
        end
    endtask

    task automatic test_ibf();
        logic [CTR_BITS-1:0] got;
        do_clear();
        bus.ibuf_valid = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        n_tests++;
        if (ibf_stalls !== 8'd4) begin
            n_fail++;
            $display("FAIL ibf_latency: got %0d, expected 4", ibf_stalls);
        end
        bus.ibuf_ready = 1'b1;
        tick();
        set_idle();
        tick();
        for (int k = 0; k < 8; k++) begin
            got = get_out(k);
            n_tests++;
            if (got !== ((k == 0) ? 8'd5 : 8'd0)) begin
                n_fail++;
                $display("FAIL ibf_5[%0d]: got %0d, expected %0d", k, got, (k == 0) ? 5 : 0);
            end
        end
    endtask

    task automatic test_alu_dispatch();
        do_clear();
        bus.ex_valid = 5'b00100;
        for (int c = 0; c < 3; c++) tick();
        bus.ex_ready    = 5'b00100;
        bus.issue_tmask = 4'b1011;
        tick();
        set_idle();
        tick();
        n_tests++;
        if (alu_stalls !== 8'd3) begin
            n_fail++;
            $display("FAIL alu_stalls: got %0d, expected 3", alu_stalls);
        end
        n_tests++;
        if (active_threads !== 8'd3) begin
            n_fail++;
            $display("FAIL alu_active: got %0d, expected 3", active_threads);
        end
        n_tests++;
        if (fpu_stalls !== 8'd0) begin
            n_fail++;
            $display("FAIL alu_fpu_zero: got %0d, expected 0", fpu_stalls);
        end
    endtask

    task automatic test_multi();
        logic [CTR_BITS-1:0] got;
        do_clear();
        bus.ibuf_valid = 1'b1;
        bus.scb_valid  = 1'b1;
        bus.ex_valid   = 5'b11111;
        bus.issue_tmask = 4'b1111;
        for (int c = 0; c < 4; c++) tick();
        // Illegal double fire (LSU+CSR) still adds the lanes once.
        set_idle();
        bus.ex_valid    = 5'b00011;
        bus.ex_ready    = 5'b00011;
        bus.issue_tmask = 4'b0111;
        tick();
        set_idle();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            got = get_out(k);
            n_tests++;
            if (got !== ((k == 7) ? 8'd3 : 8'd4)) begin
                n_fail++;
                $display("FAIL multi[%0d]: got %0d, expected %0d", k, got, (k == 7) ? 3 : 4);
            end
        end
    endtask

    task automatic test_clear();
        do_clear();
        bus.ibuf_valid = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        n_tests++;
        if (ibf_stalls !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_zero: got %0d, expected 0", ibf_stalls);
        end
        tick();
        n_tests++;
        if (ibf_stalls !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_drop: got %0d, expected 0", ibf_stalls);
        end
        for (int c = 0; c < 4; c++) tick();
        n_tests++;
        if (ibf_stalls !== 8'd4) begin
            n_fail++;
            $display("FAIL clr_resume: got %0d, expected 4", ibf_stalls);
        end
        set_idle();
    endtask

    task automatic test_perf_en();
        logic [4:0] en_pat;
        en_pat = 5'b10011;  // LSB first: 1,1,0,0,1
        do_clear();
        bus.scb_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            perf_en = en_pat[c];
            tick();
        end
        perf_en = 1'b0;
        tick();
        tick();
        n_tests++;
        if (scb_stalls !== 8'd3) begin
            n_fail++;
            $display("FAIL perf_en: got %0d, expected 3", scb_stalls);
        end
        perf_en = 1'b1;
        set_idle();
    endtask

    task automatic test_wrap();
        logic [CTR_BITS-1:0] exp_v;
        do_clear();
        bus.ex_valid    = 5'b00100;
        bus.ex_ready    = 5'b00100;
        bus.issue_tmask = 4'b1111;
        for (int c = 0; c < 63; c++) tick();
        bus.issue_tmask = 4'b0011;
        tick();
        set_idle();
        tick();
        n_tests++;
        if (active_threads !== 8'd254) begin
            n_fail++;
            $display("FAIL thr_254: got %0d, expected 254", active_threads);
        end
        bus.ex_valid    = 5'b00100;
        bus.ex_ready    = 5'b00100;
        bus.issue_tmask = 4'b1111;
        tick();
        set_idle();
        tick();
`ifdef PERF_CTR_SATURATE_EN
        exp_v = 8'd255;
`else
        exp_v = 8'd2;
`endif
        n_tests++;
        if (active_threads !== exp_v) begin
            n_fail++;
            $display("FAIL thr_wrap: got %0d, expected %0d", active_threads, exp_v);
        end
        bus.ex_valid    = 5'b00100;
        bus.ex_ready    = 5'b00100;
        bus.issue_tmask = 4'b1111;
        tick();
        set_idle();
        tick();
`ifdef PERF_CTR_SATURATE_EN
        exp_v = 8'd255;
`else
        exp_v = 8'd6;
`endif
        n_tests++;
        if (active_threads !== exp_v) begin
            n_fail++;
            $display("FAIL thr_after_wrap: got %0d, expected %0d", active_threads, exp_v);
        end

        do_clear();
        bus.ibuf_valid = 1'b1;
        for (int c = 0; c < 255; c++) tick();
        set_idle();
        tick();
        n_tests++;
        if (ibf_stalls !== 8'd255) begin
            n_fail++;
            $display("FAIL ibf_255: got %0d, expected 255", ibf_stalls);
        end
        bus.ibuf_valid = 1'b1;
        tick();
        set_idle();
        tick();
`ifdef PERF_CTR_SATURATE_EN
        exp_v = 8'd255;
`else
        exp_v = 8'd0;
`endif
        n_tests++;
        if (ibf_stalls !== exp_v) begin
            n_fail++;
            $display("FAIL ibf_wrap: got %0d, expected %0d", ibf_stalls, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        bus.ibuf_valid = 1'b1;
        bus.ex_valid    = 5'b00001;
        bus.ex_ready    = 5'b00001;
        bus.issue_tmask = 4'b0101;
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (ibf_stalls !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %0d, expected 0", ibf_stalls);
        end
        set_idle();
        #2 reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (ibf_stalls !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_pending_ibf: got %0d, expected 0", ibf_stalls);
        end
        n_tests++;
        if (active_threads !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_pending_thr: got %0d, expected 0", active_threads);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        perf_en  = 1'b1;
        perf_clr = 1'b0;
        set_idle();
        test_reset();
        test_ibf();
        test_alu_dispatch();
        test_multi();
        test_clear();
        test_perf_en();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
